// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode definitions: opcode patterns, ALU codes, instruction classes and the
// control bundle registered by the decode stage.
package legv8_pkg;

    localparam logic [10:0] OP_ADD    = 11'b10001011000;
    localparam logic [10:0] OP_SUB    = 11'b11001011000;
    localparam logic [10:0] OP_AND    = 11'b10001010000;
    localparam logic [10:0] OP_ORR    = 11'b10101010000;
    localparam logic [10:0] OP_LDUR   = 11'b11111000010;
    localparam logic [10:0] OP_STUR   = 11'b11111000000;
    // Prefix opcodes: compared against the top bits of instruction[31:21] only
    localparam logic [9:0]  OP_ADDI_P = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI_P = 10'b1101000100;
    localparam logic [7:0]  OP_CBZ_P  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ_P = 8'b10110101;
    localparam logic [5:0]  OP_B_P    = 6'b000101;
    localparam logic [5:0]  OP_BL_P   = 6'b100101;

    localparam logic [3:0]  ALU_AND   = 4'b0000;
    localparam logic [3:0]  ALU_ORR   = 4'b0001;
    localparam logic [3:0]  ALU_ADD   = 4'b0010;
    localparam logic [3:0]  ALU_SUB   = 4'b0110;
    localparam logic [3:0]  ALU_PASSB = 4'b0111;

    localparam logic [4:0]  LINK_REG  = 5'd30;

    typedef enum logic [2:0] {
        CLS_R, CLS_I, CLS_D_LD, CLS_D_ST, CLS_CB, CLS_B, CLS_BL, CLS_ILLEGAL
    } instr_class_e;

    typedef enum logic {ST_RUN, ST_STALL} stage_state_e;

    typedef struct packed {
        logic       uncond_branch;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [3:0] alu_ctrl;
        logic [4:0] rd_reg1;
        logic [4:0] rd_reg2;
        logic [4:0] wr_reg;
        logic       illegal;
    } ctrl_bundle_t;

    function automatic logic reads_rn(input instr_class_e cls);
        return (cls == CLS_R) || (cls == CLS_I) || (cls == CLS_D_LD) ||
               (cls == CLS_D_ST) || (cls == CLS_CB);
    endfunction

    function automatic logic reads_rm(input instr_class_e cls);
        return (cls == CLS_R) || (cls == CLS_D_ST) || (cls == CLS_CB);
    endfunction

endpackage

// File: rtl/legv8_decode_comb.sv
// Combinational LEGv8 instruction decode into control bundle, class and extended immediate.
// Zero latency, no state, no backpressure.
module legv8_decode_comb
    import legv8_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [31:0]           i_instr,
    output instr_class_e          o_cls,
    output ctrl_bundle_t          o_ctrl,
    output logic [DATA_WIDTH-1:0] o_imm
);

    logic [10:0]  w_op;
    logic [3:0]   w_alu;
    instr_class_e w_cls;

    assign w_op  = i_instr[31:21];
    assign o_cls = w_cls;

    always_comb begin
        w_cls = CLS_ILLEGAL;
        w_alu = ALU_AND;
        if (w_op == OP_ADD) begin
            w_cls = CLS_R;    w_alu = ALU_ADD;
        end else if (w_op == OP_SUB) begin
            w_cls = CLS_R;    w_alu = ALU_SUB;
        end else if (w_op == OP_AND) begin
            w_cls = CLS_R;    w_alu = ALU_AND;
        end else if (w_op == OP_ORR) begin
            w_cls = CLS_R;    w_alu = ALU_ORR;
        end else if (w_op[10:1] == OP_ADDI_P) begin
            w_cls = CLS_I;    w_alu = ALU_ADD;
        end else if (w_op[10:1] == OP_SUBI_P) begin
            w_cls = CLS_I;    w_alu = ALU_SUB;
        end else if (w_op == OP_LDUR) begin
            w_cls = CLS_D_LD; w_alu = ALU_ADD;
        end else if (w_op == OP_STUR) begin
            w_cls = CLS_D_ST; w_alu = ALU_ADD;
        end else if ((w_op[10:3] == OP_CBZ_P) || (w_op[10:3] == OP_CBNZ_P)) begin
            w_cls = CLS_CB;   w_alu = ALU_PASSB;
        end else if (w_op[10:5] == OP_B_P) begin
            w_cls = CLS_B;
        end else if (w_op[10:5] == OP_BL_P) begin
            w_cls = CLS_BL;
        end
    end

    always_comb begin
        o_ctrl          = '0;
        o_imm           = '0;
        o_ctrl.alu_ctrl = w_alu;
        o_ctrl.rd_reg1  = i_instr[9:5];
        o_ctrl.rd_reg2  = i_instr[20:16];
        o_ctrl.wr_reg   = i_instr[4:0];
        case (w_cls)
            CLS_R: begin
                o_ctrl.reg_write = 1'b1;
            end
            CLS_I: begin
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_imm            = {{(DATA_WIDTH-12){1'b0}}, i_instr[21:10]};
            end
            CLS_D_LD: begin
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.mem_read   = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_write  = 1'b1;
                o_imm             = {{(DATA_WIDTH-9){i_instr[20]}}, i_instr[20:12]};
            end
            CLS_D_ST: begin
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.mem_write = 1'b1;
                o_ctrl.rd_reg2   = i_instr[4:0];
                o_imm            = {{(DATA_WIDTH-9){i_instr[20]}}, i_instr[20:12]};
            end
            CLS_CB: begin
                o_ctrl.branch  = 1'b1;
                o_ctrl.rd_reg2 = i_instr[4:0];
                o_imm          = {{(DATA_WIDTH-21){i_instr[23]}}, i_instr[23:5], 2'b00};
            end
            CLS_B: begin
                o_ctrl.uncond_branch = 1'b1;
                o_imm                = {{(DATA_WIDTH-28){i_instr[25]}}, i_instr[25:0], 2'b00};
            end
            CLS_BL: begin
                o_ctrl.uncond_branch = 1'b1;
                o_ctrl.reg_write     = 1'b1;
                o_ctrl.wr_reg        = LINK_REG;
                o_imm                = {{(DATA_WIDTH-28){i_instr[25]}}, i_instr[25:0], 2'b00};
            end
            default: begin
                o_ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_control_stage.sv
// Registered LEGv8 decode stage with load-use interlock; 1-cycle latency.
// Holds the bundle while outReady is low; inReady drops on downstream stall, hazard or bubble.
module decode_control_stage
    import legv8_pkg::*;
#(
    parameter int DATA_WIDTH       = 64,
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int ZERO_REG         = 31
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic [31:0]           instruction,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic                  flush,
    output logic                  outValid,
    input  logic                  outReady,
    output logic                  unconditionalBranch,
    output logic                  branch,
    output logic                  memRead,
    output logic                  memToReg,
    output logic                  memWrite,
    output logic                  aluSRC,
    output logic                  regWriteFlag,
    output logic [3:0]            aluControlCode,
    output logic [4:0]            readRegister1,
    output logic [4:0]            readRegister2,
    output logic [4:0]            writeRegister,
    output logic [DATA_WIDTH-1:0] immediate,
    output logic                  illegalInstr
);

    localparam logic [4:0] ZERO_ID       = 5'(ZERO_REG);
    localparam logic       INTERLOCK_EN  = (LOAD_USE_BUBBLES != 0);
    localparam logic [1:0] BUBBLE_INIT   = (LOAD_USE_BUBBLES > 0) ? 2'(LOAD_USE_BUBBLES - 1) : 2'd0;

    instr_class_e          w_cls;
    ctrl_bundle_t          w_ctrl;
    logic [DATA_WIDTH-1:0] w_imm;
    logic                  w_hazard;
    logic                  w_in_xfer;
    logic                  w_out_xfer;
    stage_state_e          w_state_nxt;
    logic [1:0]            w_cnt_nxt;

    ctrl_bundle_t          r_bundle;
    logic [DATA_WIDTH-1:0] r_imm;
    logic                  r_out_vld;
    stage_state_e          r_state;
    logic [1:0]            r_bubble_cnt;

    legv8_decode_comb #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_decode (
        .i_instr (instruction),
        .o_cls   (w_cls),
        .o_ctrl  (w_ctrl),
        .o_imm   (w_imm)
    );

    // Load in the output register whose destination the incoming instruction sources
    assign w_hazard = INTERLOCK_EN && r_out_vld && r_bundle.mem_read &&
                      (r_bundle.wr_reg != ZERO_ID) && inValid &&
                      ((reads_rn(w_cls) && (w_ctrl.rd_reg1 == r_bundle.wr_reg)) ||
                       (reads_rm(w_cls) && (w_ctrl.rd_reg2 == r_bundle.wr_reg)));

    assign inReady    = (!r_out_vld || outReady) && (r_state == ST_RUN) && !w_hazard;
    assign w_in_xfer  = inValid && inReady;
    assign w_out_xfer = r_out_vld && outReady;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_bubble_cnt;
        if (flush) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = 2'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_hazard && w_out_xfer) begin
                        w_state_nxt = ST_STALL;
                        w_cnt_nxt   = BUBBLE_INIT;
                    end
                end
                ST_STALL: begin
                    if (r_bubble_cnt == 2'd0) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_cnt_nxt = r_bubble_cnt - 2'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state      <= ST_RUN;
            r_bubble_cnt <= 2'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_bubble_cnt <= w_cnt_nxt;
        end
    end

    // Flush wins over a same-cycle accept so a squashed instruction never lands
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_out_vld <= 1'b0;
            r_bundle  <= '0;
            r_imm     <= '0;
        end else if (flush) begin
            r_out_vld <= 1'b0;
        end else if (w_in_xfer) begin
            r_out_vld <= 1'b1;
            r_bundle  <= w_ctrl;
            r_imm     <= w_imm;
        end else if (w_out_xfer) begin
            r_out_vld <= 1'b0;
        end
    end

    assign outValid            = r_out_vld;
    assign unconditionalBranch = r_bundle.uncond_branch;
    assign branch              = r_bundle.branch;
    assign memRead             = r_bundle.mem_read;
    assign memToReg            = r_bundle.mem_to_reg;
    assign memWrite            = r_bundle.mem_write;
    assign aluSRC              = r_bundle.alu_src;
    assign regWriteFlag        = r_bundle.reg_write;
    assign aluControlCode      = r_bundle.alu_ctrl;
    assign readRegister1       = r_bundle.rd_reg1;
    assign readRegister2       = r_bundle.rd_reg2;
    assign writeRegister       = r_bundle.wr_reg;
    assign immediate           = r_imm;
    assign illegalInstr        = r_bundle.illegal;

endmodule

// File: tb/tb_decode_control_stage.sv
// Directed bench for decode_control_stage: decode vector table plus hand-written
// interlock, backpressure, flush and reset sequences.
module tb_decode_control_stage;

    typedef struct packed {
        logic        uncond;
        logic        branch;
        logic        mem_read;
        logic        mem_to_reg;
        logic        mem_write;
        logic        alu_src;
        logic        reg_write;
        logic [3:0]  alu;
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic [4:0]  wr;
        logic        illegal;
        logic [63:0] imm;
    } obs_t;

    typedef struct {
        logic [31:0] instr;
        obs_t        exp;
        obs_t        mask;
    } vec_t;

    localparam logic [31:0] I_ADD3    = 32'h8B020023;  // ADD X3,X1,X2
    localparam logic [31:0] I_SUB     = 32'hCB0600A4;  // SUB X4,X5,X6
    localparam logic [31:0] I_AND     = 32'h8A030041;  // AND X1,X2,X3
    localparam logic [31:0] I_ORR     = 32'hAA0C016A;  // ORR X10,X11,X12
    localparam logic [31:0] I_ADDI    = 32'h913FFC47;  // ADDI X7,X2,#4095
    localparam logic [31:0] I_SUBI    = 32'hD1000421;  // SUBI X1,X1,#1
    localparam logic [31:0] I_LDUR5   = 32'hF8408025;  // LDUR X5,[X1,#8]
    localparam logic [31:0] I_LDUR31  = 32'hF840803F;  // LDUR XZR,[X1,#8]
    localparam logic [31:0] I_STUR    = 32'hF81F8049;  // STUR X9,[X2,#-8]
    localparam logic [31:0] I_CBZ     = 32'hB4FFFFE4;  // CBZ X4,#-1
    localparam logic [31:0] I_CBNZ    = 32'hB5000043;  // CBNZ X3,#2
    localparam logic [31:0] I_B       = 32'h17FFFFFE;  // B #-2
    localparam logic [31:0] I_BL      = 32'h94000004;  // BL #4
    localparam logic [31:0] I_ILL     = 32'hFFFFFFFF;
    localparam logic [31:0] I_ADD6_5  = 32'h8B0200A6;  // ADD X6,X5,X2
    localparam logic [31:0] I_ADD6_31 = 32'h8B0203E6;  // ADD X6,XZR,X2

    logic        clock = 1'b0;
    logic        resetN;
    logic [31:0] instruction;
    logic        inValid, inReady, flush, outValid, outReady;
    logic        unconditionalBranch, branch, memRead, memToReg, memWrite, aluSRC, regWriteFlag;
    logic [3:0]  aluControlCode;
    logic [4:0]  readRegister1, readRegister2, writeRegister;
    logic [63:0] immediate;
    logic        illegalInstr;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    decode_control_stage #(
        .DATA_WIDTH       (64),
        .LOAD_USE_BUBBLES (1),
        .ZERO_REG         (31)
    ) dut (
        .clock               (clock),
        .resetN              (resetN),
        .instruction         (instruction),
        .inValid             (inValid),
        .inReady             (inReady),
        .flush               (flush),
        .outValid            (outValid),
        .outReady            (outReady),
        .unconditionalBranch (unconditionalBranch),
        .branch              (branch),
        .memRead             (memRead),
        .memToReg            (memToReg),
        .memWrite            (memWrite),
        .aluSRC              (aluSRC),
        .regWriteFlag        (regWriteFlag),
        .aluControlCode      (aluControlCode),
        .readRegister1       (readRegister1),
        .readRegister2       (readRegister2),
        .writeRegister       (writeRegister),
        .immediate           (immediate),
        .illegalInstr        (illegalInstr)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    function automatic obs_t get_obs();
        return {unconditionalBranch, branch, memRead, memToReg, memWrite, aluSRC, regWriteFlag,
                aluControlCode, readRegister1, readRegister2, writeRegister, illegalInstr, immediate};
    endfunction

    // flags order: {uncond, branch, memRead, memToReg, memWrite, aluSRC, regWrite}
    function automatic obs_t mk(input logic [6:0] flags, input logic [3:0] alu, input logic [4:0] rr1,
                                input logic [4:0] rr2, input logic [4:0] wr, input logic ill,
                                input logic [63:0] imm);
        return {flags, alu, rr1, rr2, wr, ill, imm};
    endfunction

    initial begin
        obs_t full_m, nr2_m, br_m, ill_m;
        vec_t tbl[13];

        full_m = '1;
        nr2_m = '1;  nr2_m.rr2 = '0;
        br_m = nr2_m; br_m.alu = '0;
        ill_m = '0;
        ill_m.uncond = 1'b1; ill_m.branch = 1'b1; ill_m.mem_read = 1'b1; ill_m.mem_to_reg = 1'b1;
        ill_m.mem_write = 1'b1; ill_m.reg_write = 1'b1; ill_m.illegal = 1'b1;

        tbl[0]  = '{I_ADD3, mk(7'b0000001, 4'b0010, 5'd1,  5'd2,  5'd3,  1'b0, 64'd0), full_m};
        tbl[1]  = '{I_SUB,  mk(7'b0000001, 4'b0110, 5'd5,  5'd6,  5'd4,  1'b0, 64'd0), full_m};
        tbl[2]  = '{I_AND,  mk(7'b0000001, 4'b0000, 5'd2,  5'd3,  5'd1,  1'b0, 64'd0), full_m};
        tbl[3]  = '{I_ORR,  mk(7'b0000001, 4'b0001, 5'd11, 5'd12, 5'd10, 1'b0, 64'd0), full_m};
        tbl[4]  = '{I_ADDI, mk(7'b0000011, 4'b0010, 5'd2,  5'd0,  5'd7,  1'b0, 64'd4095), nr2_m};
        tbl[5]  = '{I_SUBI, mk(7'b0000011, 4'b0110, 5'd1,  5'd0,  5'd1,  1'b0, 64'd1), nr2_m};
        tbl[6]  = '{I_LDUR5, mk(7'b0011011, 4'b0010, 5'd1, 5'd0,  5'd5,  1'b0, 64'd8), nr2_m};
        tbl[7]  = '{I_STUR, mk(7'b0000110, 4'b0010, 5'd2,  5'd9,  5'd9,  1'b0, 64'hFFFF_FFFF_FFFF_FFF8), full_m};
        tbl[8]  = '{I_CBZ,  mk(7'b0100000, 4'b0111, 5'd31, 5'd4,  5'd4,  1'b0, 64'hFFFF_FFFF_FFFF_FFFC), full_m};
        tbl[9]  = '{I_CBNZ, mk(7'b0100000, 4'b0111, 5'd2,  5'd3,  5'd3,  1'b0, 64'd8), full_m};
        tbl[10] = '{I_B,    mk(7'b1000000, 4'b0000, 5'd31, 5'd0,  5'd30, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8), br_m};
        tbl[11] = '{I_BL,   mk(7'b1000001, 4'b0000, 5'd0,  5'd0,  5'd30, 1'b0, 64'd16), br_m};
        tbl[12] = '{I_ILL,  mk(7'b0000000, 4'b0000, 5'd0,  5'd0,  5'd0,  1'b1, 64'd0), ill_m};

        resetN = 1'b0; instruction = '0; inValid = 1'b0; flush = 1'b0; outReady = 1'b0;
        repeat (2) tick();
        chk("reset outValid", outValid, 1'b0);
        chk("reset bundle", get_obs(), '0);
        resetN = 1'b1;
        #1 chk("reset inReady", inReady, 1'b1);

        // Decode table, one instruction per cycle with downstream always ready
        outReady = 1'b1;
        for (int i = 0; i < 13; i++) begin
            instruction = tbl[i].instr;
            inValid     = 1'b1;
            #1 chk($sformatf("vec%0d inReady", i), inReady, 1'b1);
            tick();
            chk($sformatf("vec%0d outValid", i), outValid, 1'b1);
            chk($sformatf("vec%0d bundle", i), get_obs() & tbl[i].mask, tbl[i].exp & tbl[i].mask);
        end
        inValid = 1'b0;
        tick();
        chk("drain outValid", outValid, 1'b0);

        // Load-use: LDUR X5 then ADD X6,X5,X2
        instruction = I_LDUR5; inValid = 1'b1;
        tick();
        instruction = I_ADD6_5;
        #1 chk("lu hazard inReady", inReady, 1'b0);
        tick();
        chk("lu bubble outValid", outValid, 1'b0);
        chk("lu bubble inReady", inReady, 1'b0);
        tick();
        chk("lu resume outValid", outValid, 1'b0);
        chk("lu resume inReady", inReady, 1'b1);
        tick();
        chk("lu add outValid", outValid, 1'b1);
        chk("lu add regs", {readRegister1, readRegister2, writeRegister}, {5'd5, 5'd2, 5'd6});
        inValid = 1'b0;
        tick();

        // Load to XZR never interlocks
        instruction = I_LDUR31; inValid = 1'b1;
        tick();
        instruction = I_ADD6_31;
        #1 chk("xzr inReady", inReady, 1'b1);
        tick();
        chk("xzr outValid", outValid, 1'b1);
        chk("xzr regs", {readRegister1, writeRegister}, {5'd31, 5'd6});
        inValid = 1'b0;
        tick();

        // Backpressure: bundle held 3+ cycles, then same-cycle handoff
        outReady = 1'b0; instruction = I_ADD3; inValid = 1'b1;
        tick();
        instruction = I_ORR;
        for (int c = 0; c < 3; c++) begin
            #1 chk($sformatf("bp%0d inReady", c), inReady, 1'b0);
            chk($sformatf("bp%0d outValid", c), outValid, 1'b1);
            chk($sformatf("bp%0d bundle", c), get_obs(), tbl[0].exp);
            tick();
        end
        outReady = 1'b1;
        #1 chk("bp release inReady", inReady, 1'b1);
        tick();
        chk("bp next outValid", outValid, 1'b1);
        chk("bp next bundle", get_obs(), tbl[3].exp);
        inValid = 1'b0;
        tick();

        // Flush with a valid bundle and a same-cycle offer
        instruction = I_ADD3; inValid = 1'b1;
        tick();
        chk("fl valid outValid", outValid, 1'b1);
        flush = 1'b1; instruction = I_SUB;
        tick();
        flush = 1'b0; inValid = 1'b0;
        chk("fl outValid", outValid, 1'b0);
        #1 chk("fl inReady", inReady, 1'b1);
        tick();
        chk("fl dropped", outValid, 1'b0);

        // Flush during the stall bubble
        instruction = I_LDUR5; inValid = 1'b1;
        tick();
        instruction = I_ADD6_5;
        tick();
        chk("fs stalled inReady", inReady, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fs outValid", outValid, 1'b0);
        #1 chk("fs inReady", inReady, 1'b1);
        tick();
        chk("fs add outValid", outValid, 1'b1);
        chk("fs add wr", writeRegister, 5'd6);
        inValid = 1'b0;
        tick();

        // Illegal opcode held, then asynchronous reset
        outReady = 1'b0; instruction = I_ILL; inValid = 1'b1;
        tick();
        inValid = 1'b0;
        chk("ill outValid", outValid, 1'b1);
        chk("ill flags", {illegalInstr, memRead, memWrite, regWriteFlag, branch, unconditionalBranch},
            6'b100000);
        resetN = 1'b0;
        #1;
        chk("rst async outValid", outValid, 1'b0);
        chk("rst async illegal", illegalInstr, 1'b0);
        tick();
        resetN = 1'b1; outReady = 1'b1;
        tick();

        // Reset in the middle of a stall
        instruction = I_LDUR5; inValid = 1'b1;
        tick();
        instruction = I_ADD6_5;
        tick();
        chk("rs stalled inReady", inReady, 1'b0);
        resetN = 1'b0;
        #1;
        chk("rs bundle", get_obs(), '0);
        chk("rs outValid", outValid, 1'b0);
        tick();
        resetN = 1'b1;
        #1 chk("rs run inReady", inReady, 1'b1);
        tick();
        chk("rs add outValid", outValid, 1'b1);
        chk("rs add wr", writeRegister, 5'd6);
        inValid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
